// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshake, iterative shifter and shift-add multiplier.
// Status flags are registered alongside the result for the branch unit.
`ifndef NOT
`define NOT  5'd0
`endif
`ifndef AND
`define AND  5'd1
`endif
`ifndef OR
`define OR   5'd2
`endif
`ifndef XOR
`define XOR  5'd3
`endif
`ifndef ADD
`define ADD  5'd4
`endif
`ifndef ADDI
`define ADDI 5'd5
`endif
`ifndef SUB
`define SUB  5'd6
`endif
`ifndef COMP
`define COMP 5'd7
`endif
`ifndef ANDI
`define ANDI 5'd8
`endif
`ifndef SRI
`define SRI  5'd9
`endif
`ifndef SLI
`define SLI  5'd10
`endif
`ifndef SRA
`define SRA  5'd11
`endif
`ifndef MUL
`define MUL  5'd12
`endif

module alu_multicycle #(
    parameter int WORD_SIZE = 16,
    parameter int SHAMT_W   = $clog2(WORD_SIZE) + 1,
    parameter bit MUL_EN    = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           opcode,
    input  logic [WORD_SIZE-1:0] input1,
    input  logic [WORD_SIZE-1:0] input2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] alu_out,
    output logic                 flag_zero,
    output logic                 flag_negative,
    output logic                 flag_carry,
    output logic                 flag_overflow,
    output logic                 busy
);

    localparam int W = WORD_SIZE;
    localparam logic [SHAMT_W-1:0] CNT_FULL = SHAMT_W'(W);
    localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);
    localparam logic [W-1:0]       W_LIMIT  = W'(W);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [1:0] {K_SLI, K_SRI, K_SRA, K_MUL} kind_t;

    state_t               state_q, state_d;
    kind_t                kind_q, kind_d;
    logic [W-1:0]         a_q, a_d;
    logic [W-1:0]         b_q, b_d;
    logic [W-1:0]         hi_q, hi_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]         res_q, res_d;
    logic                 zf_q, zf_d;
    logic                 nf_q, nf_d;
    logic                 cf_q, cf_d;
    logic                 vf_q, vf_d;

    logic                 accept;
    logic [W:0]           add_w;
    logic [W:0]           sub_w;
    logic [SHAMT_W-1:0]   shamt;
    logic [W-1:0]         sh_next;
    logic                 sh_out;
    logic [W:0]           mul_sum;
    logic [W-1:0]         mul_lo;
    logic                 fin;
    logic [W-1:0]         fin_res;
    logic                 fin_c;
    logic                 fin_v;
    logic                 start_shift;
    kind_t                sh_kind;

    always_comb begin
        add_w = {1'b0, input1} + {1'b0, input2};
        sub_w = {1'b0, input1} - {1'b0, input2};
        shamt = (input2 >= W_LIMIT) ? CNT_FULL : input2[SHAMT_W-1:0];

        sh_next = a_q;
        sh_out  = 1'b0;
        unique case (kind_q)
            K_SLI:   {sh_out, sh_next} = {a_q, 1'b0};
            K_SRI:   {sh_next, sh_out} = {1'b0, a_q};
            K_SRA:   {sh_next, sh_out} = {a_q[W-1], a_q};
            default: begin
                sh_next = a_q;
                sh_out  = 1'b0;
            end
        endcase

        // One shift-add step on the {hi, b} product register.
        mul_sum = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_lo  = {mul_sum[0], b_q[W-1:1]};
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        a_d         = a_q;
        b_d         = b_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        zf_d        = zf_q;
        nf_d        = nf_q;
        cf_d        = cf_q;
        vf_d        = vf_q;
        fin         = 1'b0;
        fin_res     = '0;
        fin_c       = 1'b0;
        fin_v       = 1'b0;
        start_shift = 1'b0;
        sh_kind     = K_SLI;

        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept   = in_valid && in_ready;

        unique case (state_q)
            IDLE: ;
            EXEC: begin
                cnt_d = cnt_q - CNT_ONE;
                fin   = (cnt_q == CNT_ONE);
                if (kind_q == K_MUL) begin
                    hi_d    = mul_sum[W:1];
                    b_d     = mul_lo;
                    fin_res = mul_lo;
                    fin_c   = |mul_sum[W:1];
                end else begin
                    a_d     = sh_next;
                    fin_res = sh_next;
                    fin_c   = sh_out;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            unique case (1'b1)
                (opcode == `NOT): begin
                    fin     = 1'b1;
                    fin_res = ~input1;
                end
                (opcode == `AND), (opcode == `ANDI): begin
                    fin     = 1'b1;
                    fin_res = input1 & input2;
                end
                (opcode == `OR): begin
                    fin     = 1'b1;
                    fin_res = input1 | input2;
                end
                (opcode == `XOR): begin
                    fin     = 1'b1;
                    fin_res = input1 ^ input2;
                end
                (opcode == `ADD), (opcode == `ADDI): begin
                    fin     = 1'b1;
                    fin_res = add_w[W-1:0];
                    fin_c   = add_w[W];
                    fin_v   = (input1[W-1] == input2[W-1])
                           && (add_w[W-1] != input1[W-1]);
                end
                (opcode == `SUB): begin
                    fin     = 1'b1;
                    fin_res = sub_w[W-1:0];
                    fin_c   = sub_w[W];
                    fin_v   = (input1[W-1] != input2[W-1])
                           && (sub_w[W-1] != input1[W-1]);
                end
                (opcode == `COMP): begin
                    fin     = 1'b1;
                    fin_res = W'(input1 == input2);
                end
                (opcode == `SLI): begin
                    start_shift = 1'b1;
                    sh_kind     = K_SLI;
                end
                (opcode == `SRI): begin
                    start_shift = 1'b1;
                    sh_kind     = K_SRI;
                end
                (opcode == `SRA): begin
                    start_shift = 1'b1;
                    sh_kind     = K_SRA;
                end
                ((opcode == `MUL) && MUL_EN): begin
                    state_d = EXEC;
                    kind_d  = K_MUL;
                    a_d     = input1;
                    b_d     = input2;
                    hi_d    = '0;
                    cnt_d   = CNT_FULL;
                end
                default: begin
                    fin     = 1'b1;
                    fin_res = '0;
                end
            endcase

            if (start_shift) begin
                kind_d = sh_kind;
                a_d    = input1;
                cnt_d  = shamt;
                if (shamt == '0) begin
                    fin     = 1'b1;
                    fin_res = input1;
                end else begin
                    state_d = EXEC;
                end
            end
        end

        if (fin) begin
            state_d = DONE;
            res_d   = fin_res;
            zf_d    = (fin_res == '0);
            nf_d    = fin_res[W-1];
            cf_d    = fin_c;
            vf_d    = fin_v;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            kind_q  <= K_SLI;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
            cf_q    <= 1'b0;
            vf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            zf_q    <= zf_d;
            nf_q    <= nf_d;
            cf_q    <= cf_d;
            vf_q    <= vf_d;
        end
    end

    assign out_valid     = (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign alu_out       = res_q;
    assign flag_zero     = zf_q;
    assign flag_negative = nf_q;
    assign flag_carry    = cf_q;
    assign flag_overflow = vf_q;

endmodule
